// File: rtl/s2p_arb_pkg.sv
// s2p_arb_pkg: shared types, defaults and round-robin pick for the s2p arbiter
package s2p_arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int N_CH_DEF    = 4;
    localparam int FRAME_W_DEF = 6;
    localparam int TIMEOUT_DEF = 16;
    localparam int MAX_CH      = 8;

    // First requesting channel at or above ptr, wrapping modulo n; returns ptr if none.
    function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && i < n && req[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/s2p_shift_core.sv
// s2p_shift_core: LSB-first deserializer shift register and bit counter (macro S2P_ARB_TIMEOUT_EN adds started)
module s2p_shift_core #(
    parameter int FRAME_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               bit_in,
`ifdef S2P_ARB_TIMEOUT_EN
    output logic               started,
`endif
    output logic [FRAME_W-1:0] frame,
    output logic               done
);
    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] shift_q;
    logic [CNT_W-1:0]   bit_cnt;

    assign frame = {bit_in, shift_q[FRAME_W-1:1]};
    assign done  = bit_cnt == CNT_W'(FRAME_W - 1);
`ifdef S2P_ARB_TIMEOUT_EN
    assign started = bit_cnt != '0;
`endif

    // Shift in one bit per transfer; counter wraps to 0 on the frame's last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= frame;
            bit_cnt <= done ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/s2p_rr_arbiter.sv
// s2p_rr_arbiter: round-robin share of one deserializer among N_CH serial channels (macro S2P_ARB_TIMEOUT_EN adds stall abort)
module s2p_rr_arbiter
    import s2p_arb_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         req_valid,
    input  logic [N_CH-1:0]         req_data,
    output logic [N_CH-1:0]         req_ready,
    output logic                    out_valid,
    output logic [FRAME_W-1:0]      out_data,
    output logic [$clog2(N_CH)-1:0] out_ch,
    input  logic                    out_ready,
    output logic                    abort_pulse
);
    localparam int CW = $clog2(N_CH);

    if (N_CH < 2 || N_CH > MAX_CH || FRAME_W < 2 || TIMEOUT < 1) begin : g_cfg_err
        $error("s2p_rr_arbiter: unsupported parameter set");
    end

    state_t             state, state_d;
    logic [CW-1:0]      grant, rr_ptr;
    logic [FRAME_W-1:0] frame;
    logic               done, rdy, xfer, last, abort;

    // Last bit only moves when the output register is free or draining this cycle.
    assign rdy       = !done || !out_valid || out_ready;
    assign req_ready = (state == BUSY && rdy) ? {{(N_CH-1){1'b0}}, 1'b1} << grant : '0;
    assign xfer      = state == BUSY && req_valid[grant] && rdy;
    assign last      = xfer && done;

`ifdef S2P_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic          started, stall, abort_q;
    logic [SW-1:0] stall_cnt;

    assign stall       = state == BUSY && started && !req_valid[grant];
    assign abort       = stall && stall_cnt == SW'(TIMEOUT - 1);
    assign abort_pulse = abort_q;

    // Count idle cycles of a started frame; any transfer or leaving BUSY restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            abort_q   <= 1'b0;
        end else begin
            abort_q   <= abort;
            stall_cnt <= (abort || xfer || state != BUSY) ? '0 : stall ? stall_cnt + 1'b1 : stall_cnt;
        end
    end
`else
    assign abort       = 1'b0;
    assign abort_pulse = 1'b0;
`endif

    s2p_shift_core #(.FRAME_W(FRAME_W)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (xfer),
        .clr      (abort),
`ifdef S2P_ARB_TIMEOUT_EN
        .started  (started),
`endif
        .bit_in   (req_data[grant]),
        .frame    (frame),
        .done     (done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Arbitrate for one cycle in IDLE, then hold the grant until the frame ends or aborts.
    always_comb begin
        state_d = state;
        state_d = (state == IDLE) ? (|req_valid ? BUSY : IDLE) : ((last || abort) ? IDLE : BUSY);
    end

    // Grant, round-robin pointer and output frame register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            if (state == IDLE && |req_valid) grant <= CW'(rr_pick(MAX_CH'(req_valid), 3'(rr_ptr), N_CH));
            if (last || abort) rr_ptr <= (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;
            if (last) begin
                out_valid <= 1'b1;
                out_data  <= frame;
                out_ch    <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/s2p_rr_arbiter.md
Name: s2p_rr_arbiter

Overview:
- Shares one serial-to-parallel deserializer among N_CH 1-bit serial requesters.
- Round-robin grant is held for one full FRAME_W-bit frame.
- Each assembled frame is presented on a valid/ready output port, tagged with its source channel.
- Sits between the serial link front-ends and the parallel frame consumer.

Parameters:
- N_CH, 4, number of serial requester channels (2..8).
- FRAME_W, 6, bits per frame.
- TIMEOUT, 16, idle cycles before a stalled frame aborts (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_CH  per-channel serial bit valid.
- req_data  in  N_CH  per-channel serial bit.
- req_ready  out  N_CH  per-channel accept.
- out_valid  out  1  assembled frame valid.
- out_data  out  FRAME_W  assembled frame; first received bit at bit 0.
- out_ch  out  $clog2(N_CH)  source channel of out_data.
- out_ready  in  1  consumer accept.
- abort_pulse  out  1  frame-abort strobe (tied 0 unless the optional feature is compiled in).

Behaviour:
- Reset values (asynchronous): state=IDLE, rr_ptr=0, grant=0, bit_cnt=0, shift reg=0, out_valid=0, out_data=0, out_ch=0, abort_pulse=0. req_ready=0 during reset.
- FSM states: IDLE and BUSY.
  - IDLE: if any req_valid is set, grant <= first set channel searching from rr_ptr upward modulo N_CH; go to BUSY next cycle. With no requests, stay IDLE. req_ready=0 in IDLE.
  - BUSY: req_ready[i] = (i==grant) && (bit_cnt!=FRAME_W-1 || !out_valid || out_ready). This is combinational from registers and out_ready; all other channels get 0.
- Bit transfer: a bit moves when req_valid[grant] && req_ready[grant].
  - Shift reg <= {bit, shift[FRAME_W-1:1]}.
  - bit_cnt increments; it holds on bubbles. There is no grant loss on bubbles.
- Frame completion is the transfer with bit_cnt==FRAME_W-1. On that edge:
  - out_data <= {bit, shift[FRAME_W-1:1]}, out_ch <= grant, out_valid <= 1.
  - bit_cnt <= 0, rr_ptr <= grant+1 (wraps to 0 after N_CH-1), state <= IDLE.
- Latency: out_valid rises the cycle after the last bit is accepted. Back-to-back frames cost FRAME_W+1 cycles each (one IDLE arbitration cycle).
- Output handshake: out_valid, out_data and out_ch are held stable until out_valid && out_ready. out_valid clears on the drain edge unless a new frame completes on the same edge; in that case the new frame loads and out_valid stays 1.
- Backpressure: the last bit of a frame is never accepted while the output is full and not draining. Earlier bits continue to flow.
- Reset mid-frame: the partial frame is discarded; the next frame restarts from bit 0 with arbitration from rr_ptr=0.
- Non-granted channels: requests are never lost. They simply see req_ready=0 until granted.

Optional Feature:
- Macro: S2P_ARB_TIMEOUT_EN.
- Enabled:
  - A stall counter runs in BUSY while bit_cnt>0 and req_valid[grant]=0; it clears on any transfer.
  - When the counter reaches TIMEOUT: discard the partial frame, bit_cnt <= 0, rr_ptr <= grant+1, state <= IDLE, and abort_pulse=1 for one cycle.
  - out_* are unaffected.
- Disabled: no stall counter, and abort_pulse is constant 0. A granted channel holds the deserializer indefinitely.

Decomposition:
- Package s2p_arb_pkg:
  - state enum {IDLE, BUSY}.
  - Default constants N_CH_DEF=4, FRAME_W_DEF=6, TIMEOUT_DEF=16.
  - Function rr_pick(req, ptr) returning the next index.
- Sub-module s2p_shift_core: shift register plus bit counter with shift_en, clr, and done outputs.
- The arbiter, FSM and output register stay in the top module.

Test Plan:
- ch0 only, bits 1,0,1,1,0,0 on consecutive cycles, out_ready=1 → out_valid=1 one cycle after the 6th bit, out_data=6'b001101, out_ch=0, req_ready[1..3]=0 throughout.
- All four channels valid continuously, out_ready=1 → frames emerge with out_ch sequence 0,1,2,3,0. Each frame takes 7 cycles; rr_ptr wraps 3→0.
- Frame A complete with out_ready=0, ch1 then sends 5 bits → req_ready[1] drops before bit 6. Raise out_ready for one cycle → A drains and ch1's frame loads on the same edge; out_valid stays 1 and out_ch=1.
- Granted ch2 sends 3 bits, drops valid for 4 cycles, then sends the remaining 3, with ch3 requesting throughout → grant stays on ch2, frame is correct, ch3 is served next. Macro off, or TIMEOUT>4.
- rst_n pulsed low after 3 bits of a ch1 frame → all outputs 0 immediately. After release, 6 new bits from ch1 give exactly those 6 bits on out_data; no stale bits appear.
- With S2P_ARB_TIMEOUT_EN and TIMEOUT=16: ch0 sends 2 bits then idles → abort_pulse high for exactly one cycle 16 cycles later, no out_valid, and the next grant goes to ch1 if it is requesting.
